// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the framed program loader.
package mem_loader_pkg;

   // Loader FSM states; fixed encodings keep waveforms and legacy tools consistent.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_DATA = 3'd2,
      ST_SKIP = 3'd3,
      ST_CSUM = 3'd4
   } state_e;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_BOUNDS  = 2'b01;
   localparam logic [1:0] ERR_CSUM    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   // addr_lo, addr_hi, cnt_lo, cnt_hi
   localparam int HDR_BYTES = 4;

   // End of the requested region, one past the last word, evaluated without wrap.
   function automatic logic [16:0] span_end(input logic [15:0] start_addr,
                                            input logic [15:0] word_cnt);
      return {1'b0, start_addr} + {1'b0, word_cnt};
   endfunction

endpackage

// File: rtl/mem_loader_word_packer.sv
// Packs a byte stream little-endian into 32-bit words. The word presented
// alongside word_valid already includes the current (4th) byte.
module word_packer
   import mem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  lane_q, lane_d;
   logic [23:0] buf_q,  buf_d;

   // Shift each accepted byte in from the top so byte k ends up in bits [8k+7:8k].
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      lane_d = lane_q;
      buf_d  = buf_q;
      if (clear) begin
         lane_d = '0;
         buf_d  = '0;
      end else if (byte_valid) begin
         lane_d = lane_q + 2'd1;
         buf_d  = {byte_in, buf_q[23:8]};
      end
   end

   assign word       = {byte_in, buf_q};
   assign word_valid = byte_valid && !clear && (lane_q == 2'd3);

   // Lane counter and partial-word buffer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q <= '0;
         buf_q  <= '0;
      end else begin
         lane_q <= lane_d;
         buf_q  <= buf_d;
      end
   end

endmodule

// File: rtl/mem_loader.sv
// Frame-based program loader: parses sync/header/payload/checksum from the
// UART byte stream, writes packed words through the RAM IO port and holds the
// CPU while a frame is in progress. Reports done or an error code per frame.
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_WIDTH  = 14,
   parameter int DEPTH          = 4096,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   output logic                     wEn_io,
   output logic [ADDRESS_WIDTH-1:0] addr_io,
   output logic [DATA_WIDTH-1:0]    dataIn_io,
   output logic                     cpu_hold,
   output logic                     done,
   output logic                     error,
   output logic [1:0]               err_code
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e                     state_q,    state_d;
   logic [1:0]                 hdr_idx_q,  hdr_idx_d;
   logic [23:0]                hdr_q,      hdr_d;
   logic [ADDRESS_WIDTH-1:0]   addr_q,     addr_d;
   logic [15:0]                cnt_q,      cnt_d;
   logic [17:0]                skip_q,     skip_d;
   logic [7:0]                 csum_q,     csum_d;
   logic [TW-1:0]              timer_q,    timer_d;
   logic                       wen_q,      wen_d;
   logic [ADDRESS_WIDTH-1:0]   addr_io_q,  addr_io_d;
   logic [DATA_WIDTH-1:0]      data_io_q,  data_io_d;
   logic                       hold_q,     hold_d;
   logic                       done_q,     done_d;
   logic                       error_q,    error_d;
   logic [1:0]                 err_code_q, err_code_d;

   logic        pk_clear;
   logic        pk_byte_valid;
   logic [31:0] pk_word;
   logic        pk_word_valid;

   // Header fields as seen when the 4th header byte is on rx_data.
   logic [15:0] hdr_addr;
   logic [15:0] hdr_cnt;
   logic        hdr_in_bounds;

   assign hdr_addr      = hdr_q[15:0];
   assign hdr_cnt       = {rx_data, hdr_q[23:16]};
   assign hdr_in_bounds = (span_end(hdr_addr, hdr_cnt) <= 17'(DEPTH));

   assign pk_byte_valid = rx_valid && (state_q == ST_DATA);

   word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (pk_clear),
      .byte_valid (pk_byte_valid),
      .byte_in    (rx_data),
      .word       (pk_word),
      .word_valid (pk_word_valid)
   );

   // Next-state logic: frame parsing, write issue, checksum and inter-byte timeout.
   always_comb begin
      state_d    = state_q;
      hdr_idx_d  = hdr_idx_q;
      hdr_d      = hdr_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      skip_d     = skip_q;
      csum_d     = csum_q;
      timer_d    = timer_q;
      wen_d      = 1'b0;
      addr_io_d  = addr_io_q;
      data_io_d  = data_io_q;
      hold_d     = hold_q;
      done_d     = done_q;
      error_d    = error_q;
      err_code_d = err_code_q;
      pk_clear   = 1'b0;

      if (state_q == ST_IDLE) begin
         timer_d = '0;
         if (rx_valid && (rx_data == SYNC_BYTE)) begin
            done_d     = 1'b0;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
            csum_d     = '0;
            hdr_idx_d  = '0;
            skip_d     = '0;
            pk_clear   = 1'b1;
            hold_d     = 1'b1;
            state_d    = ST_HDR;
         end
      end else if (rx_valid) begin
         timer_d = '0;
         unique case (state_q)
            ST_HDR: begin
               csum_d    = csum_q + rx_data;
               hdr_d     = {rx_data, hdr_q[23:8]};
               hdr_idx_d = hdr_idx_q + 2'd1;
               if (hdr_idx_q == 2'(HDR_BYTES - 1)) begin
                  addr_d = hdr_addr[ADDRESS_WIDTH-1:0];
                  cnt_d  = hdr_cnt;
                  skip_d = {hdr_cnt, 2'b00};
                  if (!hdr_in_bounds) begin
                     err_code_d = ERR_BOUNDS;
                     state_d    = ST_SKIP;
                  end else if (hdr_cnt == 16'd0) begin
                     state_d = ST_CSUM;
                  end else begin
                     state_d = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               csum_d = csum_q + rx_data;
               if (pk_word_valid) begin
                  wen_d     = 1'b1;
                  addr_io_d = addr_q;
                  data_io_d = pk_word;
                  addr_d    = addr_q + ADDRESS_WIDTH'(1);
                  cnt_d     = cnt_q - 16'd1;
                  if (cnt_q == 16'd1) begin
                     state_d = ST_CSUM;
                  end
               end
            end
            ST_SKIP: begin
               // The byte seen with skip_q == 0 is the discarded checksum.
               if (skip_q == '0) begin
                  error_d = 1'b1;
                  hold_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  skip_d = skip_q - 18'd1;
               end
            end
            ST_CSUM: begin
               if (rx_data == csum_q) begin
                  done_d = 1'b1;
               end else begin
                  error_d    = 1'b1;
                  err_code_d = ERR_CSUM;
               end
               hold_d  = 1'b0;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (timer_q == TIMER_LAST) begin
         error_d    = 1'b1;
         err_code_d = ERR_TIMEOUT;
         hold_d     = 1'b0;
         timer_d    = '0;
         state_d    = ST_IDLE;
      end else begin
         timer_d = timer_q + TW'(1);
      end
   end

   // State registers with synchronous reset; a reset mid-frame discards everything.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q    <= ST_IDLE;
         hdr_idx_q  <= '0;
         hdr_q      <= '0;
         addr_q     <= '0;
         cnt_q      <= '0;
         skip_q     <= '0;
         csum_q     <= '0;
         timer_q    <= '0;
         wen_q      <= 1'b0;
         addr_io_q  <= '0;
         data_io_q  <= '0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         hdr_idx_q  <= hdr_idx_d;
         hdr_q      <= hdr_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         skip_q     <= skip_d;
         csum_q     <= csum_d;
         timer_q    <= timer_d;
         wen_q      <= wen_d;
         addr_io_q  <= addr_io_d;
         data_io_q  <= data_io_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
      end
   end

   assign wEn_io    = wen_q;
   assign addr_io   = addr_io_q;
   assign dataIn_io = data_io_q;
   assign cpu_hold  = hold_q;
   assign done      = done_q;
   assign error     = error_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table of frames plus hand-written
// sequences for IDLE noise, timeout and mid-frame reset.
module tb_mem_loader;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        wEn_io;
   logic [13:0] addr_io;
   logic [31:0] dataIn_io;
   logic        cpu_hold, done, error;
   logic [1:0]  err_code;

   mem_loader #(
      .DATA_WIDTH     (32),
      .ADDRESS_WIDTH  (14),
      .DEPTH          (4096),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .wEn_io    (wEn_io),
      .addr_io   (addr_io),
      .dataIn_io (dataIn_io),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [13:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] cnt;
      logic [63:0] payload;
      logic [7:0]  csum_adj;
      int          gap;
      logic        exp_done;
      logic        exp_error;
      logic [1:0]  exp_code;
   } vec_t;

   wr_t  sb_q[$];
   vec_t vecs[6];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int frame_id = 0;
   int period   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Write monitor: pops the scoreboard on every write strobe and checks cadence.
   int prev_cyc   = 0;
   int prev_frame = -1;
   always @(negedge clk) begin
      if (wEn_io === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
         end else begin
            wr_t e;
            e = sb_q.pop_front();
            check("wr_addr", {18'd0, addr_io}, {18'd0, e.addr});
            check("wr_data", dataIn_io, e.data);
         end
         if (prev_frame == frame_id && period != 0)
            check("wr_period", cyc - prev_cyc, period);
         prev_cyc   = cyc;
         prev_frame = frame_id;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [15:0] addr, input logic [15:0] cnt,
                             input logic [63:0] payload, input logic [7:0] adj,
                             input int gap);
      logic [7:0]  sum;
      logic [7:0]  b;
      logic [31:0] hdr;
      bit          inb;
      wr_t         w;
      frame_id++;
      period = 4 * (gap + 1);
      inb = ({1'b0, addr} + {1'b0, cnt}) <= 17'd4096;
      hdr = {cnt, addr};
      send_byte(8'hA5);
      sum = 8'd0;
      for (int i = 0; i < 4; i++) begin
         b   = hdr[8*i +: 8];
         sum = sum + b;
         send_byte(b);
      end
      for (int i = 0; i < 4 * int'(cnt); i++) begin
         b   = payload[8*(i%8) +: 8];
         sum = sum + b;
         if (inb && (i % 4 == 3)) begin
            w.addr = addr[13:0] + 14'(i / 4);
            w.data = payload[32*((i/4)%2) +: 32];
            sb_q.push_back(w);
         end
         send_byte(b);
         if (gap > 0) idle(gap);
      end
      send_byte(sum + adj);
   endtask

   task automatic check_status(input string tag, input logic d, input logic e, input logic [1:0] c);
      check({tag, "_done"},     {31'd0, done},     {31'd0, d});
      check({tag, "_error"},    {31'd0, error},    {31'd0, e});
      check({tag, "_err_code"}, {30'd0, err_code}, {30'd0, c});
      check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
      check({tag, "_sb_empty"}, sb_q.size(),       32'd0);
   endtask

   initial begin
      vecs[0] = '{16'h0010, 16'd2, 64'h8877665544332211, 8'd0, 0, 1'b1, 1'b0, 2'b00};
      vecs[1] = '{16'h0010, 16'd2, 64'h8877665544332211, 8'd1, 0, 1'b0, 1'b1, 2'b10};
      vecs[2] = '{16'h0FFF, 16'd2, 64'h8877665544332211, 8'd0, 0, 1'b0, 1'b1, 2'b01};
      vecs[3] = '{16'h0100, 16'd0, 64'h0,                8'd0, 0, 1'b1, 1'b0, 2'b00};
      vecs[4] = '{16'h0FFE, 16'd2, 64'hA50013A5A55AA501, 8'd0, 0, 1'b1, 1'b0, 2'b00};
      vecs[5] = '{16'h0000, 16'd1, 64'h00000000AABBCCDD, 8'd0, 2, 1'b1, 1'b0, 2'b00};

      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(3);
      check("rst_wEn_io",   {31'd0, wEn_io},   32'd0);
      check("rst_addr_io",  {18'd0, addr_io},  32'd0);
      check("rst_dataIn",   dataIn_io,         32'd0);
      check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      check("rst_done",     {31'd0, done},     32'd0);
      check("rst_error",    {31'd0, error},    32'd0);
      check("rst_err_code", {30'd0, err_code}, 32'd0);
      reset = 1'b0;
      idle(2);

      // Table of whole frames; the OOB frame is followed by a good one.
      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].addr, vecs[v].cnt, vecs[v].payload, vecs[v].csum_adj, vecs[v].gap);
         idle(2);
         check_status($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_error, vecs[v].exp_code);
      end

      // Noise in IDLE is ignored; hold rises the cycle after the sync byte.
      frame_id++;
      period = 0;
      send_byte(8'h00);
      check("noise00_hold", {31'd0, cpu_hold}, 32'd0);
      send_byte(8'h13);
      check("noise13_hold", {31'd0, cpu_hold}, 32'd0);
      send_byte(8'hA5);
      check("sync_hold",    {31'd0, cpu_hold}, 32'd1);
      check("sync_clr_done", {31'd0, done},    32'd0);
      send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h40);
      idle(1);
      check_status("noise", 1'b1, 1'b0, 2'b00);

      // Stall after two bytes of a word: timeout, no write, back in IDLE.
      frame_id++;
      send_byte(8'hA5);
      send_byte(8'h20); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hDE); send_byte(8'hAD);
      idle(TO - 4);
      check("to_early_error", {31'd0, error},    32'd0);
      check("to_early_hold",  {31'd0, cpu_hold}, 32'd1);
      idle(10);
      check_status("timeout", 1'b0, 1'b1, 2'b11);
      send_frame(16'h0020, 16'd1, 64'h0000000012345678, 8'd0, 0);
      idle(2);
      check_status("after_to", 1'b1, 1'b0, 2'b00);

      // Reset mid-DATA: everything clears next cycle and the partial word is dropped.
      frame_id++;
      send_byte(8'hA5);
      send_byte(8'h30); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02);
      reset = 1'b1;
      idle(1);
      check("mid_rst_wEn",   {31'd0, wEn_io},   32'd0);
      check("mid_rst_hold",  {31'd0, cpu_hold}, 32'd0);
      check("mid_rst_addr",  {18'd0, addr_io},  32'd0);
      check("mid_rst_data",  dataIn_io,         32'd0);
      check("mid_rst_done",  {31'd0, done},     32'd0);
      check("mid_rst_error", {31'd0, error},    32'd0);
      check("mid_rst_code",  {30'd0, err_code}, 32'd0);
      reset = 1'b0;
      send_byte(8'h03); send_byte(8'h04);
      idle(3);
      check_status("post_rst", 1'b0, 1'b0, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_loader.md
# mem_loader

Frame-based program loader on the IO side of the dual-port data/instruction RAM. It takes a byte stream from the UART receiver, parses a framed header, and packs payload bytes little-endian into 32-bit words. Each word is written through the RAM's IO write port, and the block holds the CPU in stall/reset for the whole load. On completion it reports done or a specific error code.

## Interface
- DATA_WIDTH, 32, RAM word width; must be 32.
- ADDRESS_WIDTH, 14, width of the RAM IO address.
- DEPTH, 4096, number of RAM words; used for the bounds check.
- TIMEOUT_CYCLES, 1000000, maximum idle gap between bytes inside a frame.
- clk  in  1  single clock for the block.
- reset  in  1  synchronous, active-high.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle. There is no backpressure.
- rx_data  in  8  received byte.
- wEn_io  out  1  one-cycle RAM IO write strobe.
- addr_io  out  ADDRESS_WIDTH  RAM word address.
- dataIn_io  out  DATA_WIDTH  RAM write data.
- cpu_hold  out  1  high while a frame is in progress.
- done  out  1  sticky: the last frame loaded with a good checksum.
- error  out  1  sticky: the last frame failed.
- err_code  out  2  01 = out of bounds, 10 = checksum mismatch, 11 = timeout.

## Operation
- Frame format: sync byte 0xA5, then addr_lo, addr_hi, cnt_lo, cnt_hi, then 4*cnt payload bytes, then one checksum byte.
  - addr is a start word address; cnt is a word count.
  - Checksum = 8-bit sum mod 256 of every byte after sync, excluding the checksum byte itself.
- States: IDLE, HDR, DATA, SKIP, CSUM.
- IDLE:
  - Ignores every byte except 0xA5.
  - On 0xA5: clears done, error and err_code; clears the checksum accumulator and byte counters; sets cpu_hold; goes to HDR.
- HDR:
  - Collects 4 bytes.
  - On the 4th byte, if addr + cnt > DEPTH (computed at 17 bits, no wrap): err_code = 01, go to SKIP.
  - Otherwise, if cnt == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA:
  - Byte k of a word lands in bits [8k+7:8k].
  - On the 4th byte: issue a write at the current address, increment the address, decrement the remaining count.
  - After the last word: go to CSUM.
- SKIP:
  - Consumes 4*cnt+1 bytes with no writes.
  - Then sets error, clears cpu_hold, goes to IDLE.
- CSUM:
  - On a match: done = 1.
  - On a mismatch: error = 1, err_code = 10.
  - Either way: clear cpu_hold, go to IDLE.
  - Words already written stay written.
- Timeout:
  - In any state other than IDLE, a gap of TIMEOUT_CYCLES cycles without rx_valid sets error = 1 and err_code = 11, clears cpu_hold, and returns to IDLE.
  - The counter reloads on every rx_valid.
- An 0xA5 byte inside HDR, DATA or SKIP is treated as data, never as a resync.
- The block never reads the RAM.

## Timing
- Reset values:
  - All outputs are 0; state is IDLE.
  - Internal address, count, accumulator and timeout counter are 0.
- Reset mid-frame aborts immediately:
  - No write is issued for a partially assembled word.
  - cpu_hold drops on the cycle after reset is sampled.
- Write latency: the 4th byte of a word is sampled at edge N. wEn_io is high for exactly the cycle after edge N, with addr_io and dataIn_io stable during that cycle.
  - Back-to-back bytes, one per cycle, are supported.
  - The worst case is a write every 4th cycle.
- addr_io and dataIn_io hold their last value when wEn_io is low.
- cpu_hold:
  - Rises the cycle after the sync byte is sampled.
  - Falls in the same cycle that done or error rises.
  - It is never low while a frame write is pending.
- A frame's final write, triggered by the last payload byte, always completes before CSUM evaluates. The checksum byte cannot arrive earlier than the cycle after that write.

## Structure
- The shared package holds:
  - the state enum;
  - SYNC_BYTE = 8'hA5;
  - ERR_BOUNDS, ERR_CSUM and ERR_TIMEOUT constants;
  - the header byte count (4).
- Sub-module word_packer: shift-in of 4 bytes, with a 2-bit lane counter, a word_valid pulse and a clear input. It is instantiated once.
- FSM, counters and checksum logic live in mem_loader.

## Test plan
- Sync 0xA5, addr 0x0010, cnt 2, bytes 11 22 33 44 55 66 77 88, correct checksum:
  - writes 0x44332211 @0x010 and 0x88776655 @0x011;
  - done = 1, cpu_hold = 0.
- Same frame with checksum +1:
  - both writes occur;
  - error = 1, err_code = 10, done = 0.
- addr 0x0FFF, cnt 2 (4097 > 4096):
  - no wEn_io for the full 9-byte remainder;
  - error = 1, err_code = 01;
  - next valid frame loads normally.
- Payload stalls for TIMEOUT_CYCLES after 2 bytes of a word:
  - no write;
  - error = 1, err_code = 11;
  - state returns to IDLE.
- Bytes 0x00, 0x13, 0xA5 in IDLE:
  - first two are ignored;
  - cpu_hold rises one cycle after 0xA5.
- Payload contains 0xA5, bytes streamed one per cycle:
  - 0xA5 is loaded as data;
  - wEn_io pulses every 4th cycle.
- Reset mid-DATA:
  - all outputs 0 next cycle;
  - no write of the partial word.
